snn_sequencer: RTL and testbench

- Controller that loads, runs and reads out the 3-layer spiking network top. It accepts host commands and a byte stream over valid/ready handshakes.
- It streams weight or input bytes into the network's shift registers and drives `execute` for a programmed number of timesteps.
- It counts the output spikes of each layer-2 neuron, then reports per-class counts and an argmax winner.
- It sits between the host-facing pin logic and the network datapath. The network top takes a load strobe from this block.

---
 rtl/snn_pkg.sv | 31 +++
 rtl/snn_spike_counter.sv | 22 ++
 rtl/snn_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_snn_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared opcodes, states and upload sizes for the spiking network sequencer
package snn_pkg;

    localparam int SNN_N_IN   = 16;
    localparam int SNN_N_HID1 = 16;
    localparam int SNN_N_HID2 = 16;
    localparam int SNN_N_OUT  = 8;

    localparam int SNN_WEIGHT_BYTES =
        (SNN_N_IN * SNN_N_HID1 + SNN_N_HID1 * SNN_N_HID2 + SNN_N_HID2 * SNN_N_OUT) / 8;
    localparam int SNN_INPUT_BYTES  = SNN_N_IN / 8;

    // Execute-to-layer-2-spike latency of the network top.
    localparam int SNN_PIPE_DEPTH   = 3;

    typedef enum logic [1:0] {
        OP_LOAD_W = 2'd0,
        OP_LOAD_X = 2'd1,
        OP_RUN    = 2'd2,
        OP_CLEAR  = 2'd3
    } snn_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_ARGMAX = 3'd4
    } snn_state_e;

endpackage

// File: rtl/snn_spike_counter.sv
// rtl/snn_spike_counter.sv - saturating per-output spike counter with synchronous clear
module snn_spike_counter #(
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                inc,
    output logic [CNT_BITS-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/snn_sequencer.sv
// rtl/snn_sequencer.sv - loads, runs and reads out the 3-layer spiking network top
module snn_sequencer
    import snn_pkg::*;
#(
    parameter int OUTPUTS      = 8,
    parameter int CNT_BITS     = 8,
    parameter int WEIGHT_BYTES = SNN_WEIGHT_BYTES,
    parameter int INPUT_BYTES  = SNN_INPUT_BYTES,
    parameter int PIPE_DEPTH   = SNN_PIPE_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic [7:0]                  cmd_arg,
    input  logic                        byte_valid,
    output logic                        byte_ready,
    input  logic [7:0]                  byte_data,
    output logic [7:0]                  snn_data,
    output logic                        snn_load,
    output logic                        snn_input_weights,
    output logic                        snn_execute,
    input  logic [OUTPUTS-1:0]          snn_spikes,
    output logic [OUTPUTS*CNT_BITS-1:0] spike_count,
    output logic [$clog2(OUTPUTS)-1:0]  winner,
    output logic                        winner_valid,
    output logic                        busy
);

    localparam int IDX_W  = $clog2(OUTPUTS);
    localparam int BCNT_W = $clog2(WEIGHT_BYTES + 1);
    localparam int DCNT_W = $clog2(PIPE_DEPTH + 1);

    snn_state_e state, state_next;

    logic                  cmd_fire;
    logic                  byte_fire;
    logic                  cnt_clr;
    logic [BCNT_W-1:0]     byte_cnt;
    logic [8:0]            step_cnt;
    logic [DCNT_W-1:0]     drain_cnt;
    logic [PIPE_DEPTH-1:0] exec_pipe;
    logic [IDX_W-1:0]      scan_idx;
    logic [IDX_W-1:0]      best_idx;
    logic [CNT_BITS-1:0]   best_val;
    logic [CNT_BITS-1:0]   scan_val;
    logic                  scan_take;
    logic [IDX_W-1:0]      scan_best_idx;
    logic [CNT_BITS-1:0]   scan_best_val;
    logic                  scan_last;

    assign cmd_ready  = (state == ST_IDLE);
    assign busy       = !cmd_ready;
    assign byte_ready = (state == ST_LOAD);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign byte_fire  = byte_valid && byte_ready;

    // Strict greater-than keeps the lowest index on ties.
    assign scan_val      = spike_count[scan_idx*CNT_BITS +: CNT_BITS];
    assign scan_take     = (scan_idx == '0) || (scan_val > best_val);
    assign scan_best_idx = scan_take ? scan_idx : best_idx;
    assign scan_best_val = scan_take ? scan_val : best_val;
    assign scan_last     = (scan_idx == IDX_W'(OUTPUTS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (snn_op_e'(cmd_op))
                        OP_LOAD_W, OP_LOAD_X: state_next = ST_LOAD;
                        OP_RUN: begin
                            state_next = ST_RUN;
                            cnt_clr    = 1'b1;
                        end
                        OP_CLEAR: cnt_clr = 1'b1;
                        default: state_next = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD:   if (byte_fire && (byte_cnt == BCNT_W'(1))) state_next = ST_IDLE;
            ST_RUN:    if (step_cnt == 9'd1) state_next = ST_DRAIN;
            ST_DRAIN:  if (drain_cnt == DCNT_W'(1)) state_next = ST_ARGMAX;
            ST_ARGMAX: if (scan_last) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snn_data          <= '0;
            snn_load          <= 1'b0;
            snn_input_weights <= 1'b0;
            snn_execute       <= 1'b0;
            winner            <= '0;
            winner_valid      <= 1'b0;
            byte_cnt          <= '0;
            step_cnt          <= '0;
            drain_cnt         <= '0;
            exec_pipe         <= '0;
            scan_idx          <= '0;
            best_idx          <= '0;
            best_val          <= '0;
        end else begin
            snn_load  <= byte_fire;
            exec_pipe <= {exec_pipe[PIPE_DEPTH-2:0], snn_execute};
            if (byte_fire) begin
                snn_data <= byte_data;
            end
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        case (snn_op_e'(cmd_op))
                            OP_LOAD_W: begin
                                snn_input_weights <= 1'b1;
                                byte_cnt          <= BCNT_W'(WEIGHT_BYTES);
                                winner_valid      <= 1'b0;
                            end
                            OP_LOAD_X: begin
                                snn_input_weights <= 1'b0;
                                byte_cnt          <= BCNT_W'(INPUT_BYTES);
                                winner_valid      <= 1'b0;
                            end
                            OP_RUN: begin
                                // Execute rises with the RUN state so it spans exactly T cycles.
                                step_cnt     <= (cmd_arg == 8'd0) ? 9'd256 : {1'b0, cmd_arg};
                                snn_execute  <= 1'b1;
                                winner_valid <= 1'b0;
                            end
                            default: begin
                                winner       <= '0;
                                winner_valid <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (byte_fire) begin
                        byte_cnt <= byte_cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    step_cnt <= step_cnt - 1'b1;
                    if (step_cnt == 9'd1) begin
                        snn_execute <= 1'b0;
                        drain_cnt   <= DCNT_W'(PIPE_DEPTH);
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt - 1'b1;
                    scan_idx  <= '0;
                end
                ST_ARGMAX: begin
                    best_idx <= scan_best_idx;
                    best_val <= scan_best_val;
                    scan_idx <= scan_idx + 1'b1;
                    if (scan_last) begin
                        winner       <= scan_best_idx;
                        winner_valid <= 1'b1;
                    end
                end
                default: begin
                    snn_execute <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < OUTPUTS; i++) begin : g_cnt
        snn_spike_counter #(
            .CNT_BITS (CNT_BITS)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (cnt_clr),
            .inc   (exec_pipe[PIPE_DEPTH-1] && snn_spikes[i]),
            .count (spike_count[i*CNT_BITS +: CNT_BITS])
        );
    end

endmodule

// File: tb/tb_snn_sequencer.sv
// tb/tb_snn_sequencer.sv - directed vector bench for snn_sequencer
module tb_snn_sequencer;
    import snn_pkg::*;

    localparam int OUTPUTS  = 8;
    localparam int CNT_BITS = 8;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        cmd_valid = 1'b0;
    logic                        cmd_ready;
    logic [1:0]                  cmd_op = 2'd0;
    logic [7:0]                  cmd_arg = 8'd0;
    logic                        byte_valid = 1'b0;
    logic                        byte_ready;
    logic [7:0]                  byte_data = 8'd0;
    logic [7:0]                  snn_data;
    logic                        snn_load;
    logic                        snn_input_weights;
    logic                        snn_execute;
    logic [OUTPUTS-1:0]          snn_spikes = '0;
    logic [OUTPUTS*CNT_BITS-1:0] spike_count;
    logic [2:0]                  winner;
    logic                        winner_valid;
    logic                        busy;

    snn_sequencer #(
        .OUTPUTS      (OUTPUTS),
        .CNT_BITS     (CNT_BITS),
        .WEIGHT_BYTES (80),
        .INPUT_BYTES  (2),
        .PIPE_DEPTH   (3)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_op            (cmd_op),
        .cmd_arg           (cmd_arg),
        .byte_valid        (byte_valid),
        .byte_ready        (byte_ready),
        .byte_data         (byte_data),
        .snn_data          (snn_data),
        .snn_load          (snn_load),
        .snn_input_weights (snn_input_weights),
        .snn_execute       (snn_execute),
        .snn_spikes        (snn_spikes),
        .spike_count       (spike_count),
        .winner            (winner),
        .winner_valid      (winner_valid),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_vec = 0;
    int n_fail = 0;
    int load_cnt = 0;
    int exec_cnt = 0;
    int overlap = 0;
    logic [7:0] load_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (snn_load) begin
            load_cnt++;
            load_q.push_back(snn_data);
        end
        if (snn_execute) exec_cnt++;
        if (snn_execute && snn_load) overlap++;
    end

    typedef struct {
        logic [7:0] arg;
        logic [7:0] spikes;
        int         exp_cnt;
        int         exp_winner;
        int         exp_exec;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int cnt_of(input int i);
        return int'(spike_count[i*CNT_BITS +: CNT_BITS]);
    endfunction

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg, output int t_acc);
        bit ok = 1'b0;
        @(negedge clk);
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_valid = 1'b1;
        for (int k = 0; k < 1000 && !ok; k++) begin
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        t_acc     = cyc;
        if (!ok) check("cmd_accept_timeout", 0, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        byte_data  = b;
        byte_valid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            if (byte_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        byte_valid = 1'b0;
        if (!ok) check("byte_accept_timeout", 0, 1);
    endtask

    task automatic wait_wv(output int t_done);
        bit ok = 1'b0;
        for (int k = 0; k < 600 && !ok; k++) begin
            @(negedge clk);
            if (winner_valid) ok = 1'b1;
        end
        t_done = cyc;
        if (!ok) check("winner_valid_timeout", 0, 1);
    endtask

    initial begin
        int t0;
        int t1;
        bit ok;

        vecs[0] = '{8'd5,  8'b0000_0101, 5,   0, 5};
        vecs[1] = '{8'd0,  8'b0000_1000, 255, 3, 256};
        vecs[2] = '{8'd3,  8'b1111_0000, 3,   4, 3};
        vecs[3] = '{8'd1,  8'b1000_0000, 1,   7, 1};
        vecs[4] = '{8'd2,  8'b0000_0000, 0,   0, 2};
        vecs[5] = '{8'd10, 8'b0100_0010, 10,  1, 10};

        repeat (2) @(negedge clk);
        check("reset_outputs_zero",
              int'(|{snn_load, snn_execute, busy, byte_ready, snn_input_weights,
                     winner_valid, winner, snn_data, spike_count}), 0);
        check("reset_cmd_ready", int'(cmd_ready), 1);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            snn_spikes = vecs[v].spikes;
            exec_cnt   = 0;
            send_cmd(OP_RUN, vecs[v].arg, t0);
            wait_wv(t1);
            check($sformatf("v%0d_latency", v), t1 - t0, vecs[v].exp_exec + 3 + 8);
            check($sformatf("v%0d_exec_cycles", v), exec_cnt, vecs[v].exp_exec);
            check($sformatf("v%0d_winner", v), int'(winner), vecs[v].exp_winner);
            for (int i = 0; i < OUTPUTS; i++) begin
                check($sformatf("v%0d_count%0d", v, i), cnt_of(i),
                      vecs[v].spikes[i] ? vecs[v].exp_cnt : 0);
            end
        end
        snn_spikes = '0;

        send_cmd(OP_LOAD_W, 8'd0, t0);
        for (int i = 0; i < 10; i++) send_byte(8'(i), 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midload_reset_outputs_zero",
              int'(|{snn_load, snn_execute, busy, byte_ready, snn_input_weights,
                     winner_valid, winner, snn_data, spike_count}), 0);
        check("midload_reset_cmd_ready", int'(cmd_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send_cmd(OP_LOAD_W, 8'd0, t0);
        load_cnt = 0;
        load_q.delete();
        for (int i = 0; i < 80; i++) send_byte(8'(i + 1), 0);
        repeat (2) @(negedge clk);
        check("loadw_pulses", load_cnt, 80);
        check("loadw_last_data", int'(load_q[$]), 80);
        check("loadw_input_weights", int'(snn_input_weights), 1);
        check("loadw_cmd_ready", int'(cmd_ready), 1);
        byte_valid = 1'b1;
        byte_data  = 8'hEE;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        @(negedge clk);
        check("loadw_extra_byte_rejected", load_cnt, 80);

        send_cmd(OP_LOAD_X, 8'd0, t0);
        load_cnt = 0;
        load_q.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 3);
        repeat (2) @(negedge clk);
        check("loadx_pulses", load_cnt, 2);
        check("loadx_byte0", int'(load_q[0]), 8'hA5);
        check("loadx_byte1", int'(load_q[1]), 8'h3C);
        check("loadx_input_weights", int'(snn_input_weights), 0);
        check("loadx_cmd_ready", int'(cmd_ready), 1);

        snn_spikes = '0;
        send_cmd(OP_RUN, 8'd8, t0);
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            snn_spikes = snn_spikes ^ 8'h42;
            if (winner_valid) ok = 1'b1;
        end
        snn_spikes = '0;
        check("tie_done", int'(ok), 1);
        check("tie_count1", cnt_of(1), 4);
        check("tie_count6", cnt_of(6), 4);
        check("tie_winner", int'(winner), 1);

        snn_spikes = 8'h80;
        send_cmd(OP_RUN, 8'd3, t0);
        cmd_op    = OP_RUN;
        cmd_arg   = 8'd2;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        t1 = cyc;
        cmd_valid = 1'b0;
        check("held_cmd_accepted", int'(ok), 1);
        check("held_cmd_delay", t1 - t0, 3 + 3 + 8 + 1);
        wait_wv(t0);
        check("held_run_count7", cnt_of(7), 2);
        check("held_run_winner", int'(winner), 7);
        snn_spikes = '0;

        send_cmd(OP_CLEAR, 8'd0, t0);
        @(negedge clk);
        check("clear_counts", int'(|spike_count), 0);
        check("clear_winner_valid", int'(winner_valid), 0);
        check("clear_winner", int'(winner), 0);
        check("clear_cmd_ready", int'(cmd_ready), 1);
        check("exec_load_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
